unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-port synchronous memory between the core's instruction-fetch port and its load/store port.
//  Both ports use a req/gnt/rvalid handshake; one transaction is in flight at a time.
//  Sits between the RV32I core and a unified code/data memory; replaces the separate instruction and data memories.
//  Also counts contended arbitrations for performance debug.
// PARAMETERS
//  LAT        1   memory read latency in cycles, legal range 1..4
//  D_PRIORITY 1   1 = load/store port always wins a conflict; 0 = round-robin
//  CNT_W      16  width of the saturating conflict counter
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-high
//  if_req       in   1   fetch request; held until if_gnt
//  if_addr      in   32  fetch word address
//  if_gnt       out  1   fetch request accepted (1-cycle pulse)
//  if_rvalid    out  1   fetch data valid (1-cycle pulse)
//  if_rdata     out  32  fetched instruction
//  d_req        in   1   load/store request; held until d_gnt
//  d_we         in   1   1 = store, 0 = load
//  d_be         in   4   store byte enables
//  d_addr       in   32  load/store address
//  d_wdata      in   32  store data
//  d_gnt        out  1   load/store request accepted (1-cycle pulse)
//  d_rvalid     out  1   load data valid / store complete (1-cycle pulse)
//  d_rdata      out  32  load data
//  mem_en       out  1   memory access strobe
//  mem_we       out  1   memory write enable
//  mem_be       out  4   memory byte enables
//  mem_addr     out  32  memory address
//  mem_wdata    out  32  memory write data
//  mem_rdata    in   32  memory read data, valid LAT cycles after the edge that samples mem_en
//  busy         out  1   state != IDLE
//  conflict_cnt out  CNT_W  saturating count of arbitrations where both ports were requesting
// BEHAVIOUR
//  - All outputs are registered. While reset is high, every output is 0, state = IDLE, last_owner = D, and the counter is 0.
//  - States: IDLE -> ACC -> WAIT -> RESP -> IDLE.
//  - Arbitration is sampled on a rising edge in IDLE or RESP only. A req seen in any other state is ignored until the next IDLE/RESP edge.
//  - Winner when only one port requests: that port.
//  - Winner when both request: D if D_PRIORITY = 1; otherwise the port that is not last_owner. last_owner then updates to the winner.
//    After reset the first RR conflict therefore goes to the fetch port.
//  - On an arbitration edge with a winner:
//    - next state = ACC.
//    - For that one cycle: the winner's gnt = 1, mem_en = 1, and mem_we = d_we (0 for fetch).
//    - mem_addr, mem_wdata and mem_be are loaded from the winner (mem_be = 4'hF and mem_wdata unchanged for fetch).
//    - mem_addr, mem_be and mem_wdata hold their values until the next grant.
//  - On an arbitration edge with no request: RESP -> IDLE; IDLE stays IDLE.
//  - ACC -> WAIT with wait counter = LAT-1. WAIT decrements the counter and leaves when it reaches 0.
//  - The exiting WAIT edge captures mem_rdata into the owner's rdata. A store does not update d_rdata.
//    The state moves to RESP, where the owner's rvalid = 1 for one cycle.
//  - Latency: request sampled at edge E1 -> gnt during E1..E2 -> rvalid during E(LAT+2)..E(LAT+3).
//  - Back-to-back: a req high at the RESP edge is granted with no idle bubble.
//  - A requester must drop req by the RESP edge unless it is requesting a new transaction.
//  - if_rdata and d_rdata hold their last captured value between responses.
//  - conflict_cnt increments on each arbitration edge where if_req and d_req are both 1, and saturates at 2^CNT_W-1.
//  - Reset mid-transaction:
//    - The transaction is abandoned: no rvalid and no further mem_en.
//    - A store already strobed is not undone.
//    - Requesters must re-issue after reset.
//  - mem_en, gnt and rvalid are never high for more than one consecutive cycle per transaction.
//  - At most one of if_gnt / d_gnt and at most one of if_rvalid / d_rvalid is high in any cycle.
// TESTING
//  1. LAT=1, if_req with if_addr=0x00000010, memory returns 0x00500093.
//     -> if_gnt + mem_en in cycle after E1, mem_addr=0x10, if_rvalid with if_rdata=0x00500093 after E3.
//  2. D_PRIORITY=1, if_req (0x20) and d_req load (0x100) raised together.
//     -> d_gnt first, if_gnt in the D RESP cycle, conflict_cnt=1.
//  3. D_PRIORITY=0, both reqs held through 4 transactions.
//     -> grants I,D,I,D; conflict_cnt=4; no idle cycle between transactions.
//  4. Store d_we=1, d_be=4'b0011, d_addr=0x100, d_wdata=0xDEADBEEF.
//     -> one cycle of mem_en=1, mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF; d_rvalid pulse; d_rdata unchanged.
//  5. LAT=3 load. -> d_rvalid after E5.
//     Repeat with reset pulsed in WAIT -> all outputs 0 immediately, no rvalid; the next request completes normally.
//  6. CNT_W=4, 20 contended arbitrations. -> conflict_cnt stops at 4'hF.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port synchronous memory between the instruction-fetch and
// load/store ports of the core, one transaction in flight at a time.
`timescale 1ns/1ps
module unified_mem_arbiter #(
  parameter int LAT        = 1,
  parameter int D_PRIORITY = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [31:0]      if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [3:0]       d_be,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             busy,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic [1:0]       dbg_state    // 0 IDLE, 1 ACC, 2 WAIT, 3 RESP
);
  // Handshake: a port holds req until it sees a one-cycle gnt; one cycle-wide rvalid
  // later marks load data / store completion. Requests are only sampled in IDLE/RESP.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_t;

  localparam logic [1:0]       W_LAT_M1 = 2'(LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           r_state, w_state_nx;
  logic [1:0]       r_wcnt, w_wcnt_nx;
  logic             r_last_d, w_last_d_nx;
  logic             r_owner_d, w_owner_d_nx;
  logic             r_owner_we, w_owner_we_nx;
  logic             r_if_gnt, w_if_gnt_nx;
  logic             r_d_gnt, w_d_gnt_nx;
  logic             r_if_rvalid, w_if_rvalid_nx;
  logic             r_d_rvalid, w_d_rvalid_nx;
  logic [31:0]      r_if_rdata, w_if_rdata_nx;
  logic [31:0]      r_d_rdata, w_d_rdata_nx;
  logic             r_mem_en, w_mem_en_nx;
  logic             r_mem_we, w_mem_we_nx;
  logic [3:0]       r_mem_be, w_mem_be_nx;
  logic [31:0]      r_mem_addr, w_mem_addr_nx;
  logic [31:0]      r_mem_wdata, w_mem_wdata_nx;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;

  logic w_arb, w_both, w_pick_d;

  assign w_arb  = (r_state == S_IDLE) || (r_state == S_RESP);
  assign w_both = if_req && d_req;
  // In a conflict the data port wins under fixed priority, else whoever did not go last.
  assign w_pick_d = d_req && (!if_req || (D_PRIORITY != 0) || !r_last_d);

  always_comb begin
    w_state_nx     = r_state;
    w_wcnt_nx      = r_wcnt;
    w_last_d_nx    = r_last_d;
    w_owner_d_nx   = r_owner_d;
    w_owner_we_nx  = r_owner_we;
    w_if_gnt_nx    = 1'b0;
    w_d_gnt_nx     = 1'b0;
    w_if_rvalid_nx = 1'b0;
    w_d_rvalid_nx  = 1'b0;
    w_if_rdata_nx  = r_if_rdata;
    w_d_rdata_nx   = r_d_rdata;
    w_mem_en_nx    = 1'b0;
    w_mem_we_nx    = 1'b0;
    w_mem_be_nx    = r_mem_be;
    w_mem_addr_nx  = r_mem_addr;
    w_mem_wdata_nx = r_mem_wdata;
    w_cnt_nx       = r_cnt;

    if (w_arb && w_both && (r_cnt != CNT_MAX)) begin
      w_cnt_nx = r_cnt + 1'b1;
    end

    case (r_state)
      S_IDLE, S_RESP: begin
        if (if_req || d_req) begin
          w_state_nx    = S_ACC;
          w_owner_d_nx  = w_pick_d;
          w_last_d_nx   = w_pick_d;
          w_mem_en_nx   = 1'b1;
          if (w_pick_d) begin
            w_d_gnt_nx     = 1'b1;
            w_owner_we_nx  = d_we;
            w_mem_we_nx    = d_we;
            w_mem_be_nx    = d_be;
            w_mem_addr_nx  = d_addr;
            w_mem_wdata_nx = d_wdata;
          end else begin
            w_if_gnt_nx    = 1'b1;
            w_owner_we_nx  = 1'b0;
            w_mem_be_nx    = 4'hF;
            w_mem_addr_nx  = if_addr;
          end
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_ACC: begin
        w_state_nx = S_WAIT;
        w_wcnt_nx  = W_LAT_M1;
      end
      S_WAIT: begin
        if (r_wcnt == 2'd0) begin
          w_state_nx = S_RESP;
          if (r_owner_d) begin
            w_d_rvalid_nx = 1'b1;
            if (!r_owner_we) w_d_rdata_nx = mem_rdata;
          end else begin
            w_if_rvalid_nx = 1'b1;
            w_if_rdata_nx  = mem_rdata;
          end
        end else begin
          w_wcnt_nx = r_wcnt - 2'd1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wcnt      <= 2'd0;
      r_last_d    <= 1'b1;
      r_owner_d   <= 1'b0;
      r_owner_we  <= 1'b0;
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_rdata  <= 32'd0;
      r_d_rdata   <= 32'd0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_wcnt      <= w_wcnt_nx;
      r_last_d    <= w_last_d_nx;
      r_owner_d   <= w_owner_d_nx;
      r_owner_we  <= w_owner_we_nx;
      r_if_gnt    <= w_if_gnt_nx;
      r_d_gnt     <= w_d_gnt_nx;
      r_if_rvalid <= w_if_rvalid_nx;
      r_d_rvalid  <= w_d_rvalid_nx;
      r_if_rdata  <= w_if_rdata_nx;
      r_d_rdata   <= w_d_rdata_nx;
      r_mem_en    <= w_mem_en_nx;
      r_mem_we    <= w_mem_we_nx;
      r_mem_be    <= w_mem_be_nx;
      r_mem_addr  <= w_mem_addr_nx;
      r_mem_wdata <= w_mem_wdata_nx;
      r_busy      <= (w_state_nx != S_IDLE);
      r_cnt       <= w_cnt_nx;
    end
  end

  assign if_gnt       = r_if_gnt;
  assign d_gnt        = r_d_gnt;
  assign if_rvalid    = r_if_rvalid;
  assign d_rvalid     = r_d_rvalid;
  assign if_rdata     = r_if_rdata;
  assign d_rdata      = r_d_rdata;
  assign mem_en       = r_mem_en;
  assign mem_we       = r_mem_we;
  assign mem_be       = r_mem_be;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign busy         = r_busy;
  assign conflict_cnt = r_cnt;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: instance A (LAT=1, fixed D priority) and
// instance B (LAT=3, round-robin, 4-bit counter), each backed by a small memory model.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;
  localparam int B_LAT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_fill = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0] exp_qa[$];
  logic [32:0] exp_qb[$];
  logic [32:0] ea, eb;

  // ---------------- instance A signals ----------------
  logic        a_if_req, a_if_gnt, a_if_rvalid, a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
  logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata;
  logic [3:0]  a_d_be, a_mem_be;
  logic        a_mem_en, a_mem_we, a_busy;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [15:0] a_cnt;
  logic [1:0]  a_dbg;

  // ---------------- instance B signals ----------------
  logic        b_if_req, b_if_gnt, b_if_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
  logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic [3:0]  b_d_be, b_mem_be;
  logic        b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_cnt;
  logic [1:0]  b_dbg;

  unified_mem_arbiter #(.LAT(1), .D_PRIORITY(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid),
    .if_rdata(a_if_rdata), .d_req(a_d_req), .d_we(a_d_we), .d_be(a_d_be), .d_addr(a_d_addr),
    .d_wdata(a_d_wdata), .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy),
    .conflict_cnt(a_cnt), .dbg_state(a_dbg)
  );

  unified_mem_arbiter #(.LAT(B_LAT), .D_PRIORITY(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
    .if_rdata(b_if_rdata), .d_req(b_d_req), .d_we(b_d_we), .d_be(b_d_be), .d_addr(b_d_addr),
    .d_wdata(b_d_wdata), .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy),
    .conflict_cnt(b_cnt), .dbg_state(b_dbg)
  );

  // ---------------- memory models ----------------
  function automatic logic [31:0] init_word(int i);
    return (i == 4) ? 32'h0050_0093 : (32'hC0DE_0000 | 32'(i));
  endfunction

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [3];

  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= init_word(i);
    end else if (a_mem_en && a_mem_we) begin
      for (int bi = 0; bi < 4; bi++)
        if (a_mem_be[bi]) mem_a[a_mem_addr[9:2]][8*bi +: 8] <= a_mem_wdata[8*bi +: 8];
    end
    pipe_a <= (a_mem_en && !a_mem_we) ? mem_a[a_mem_addr[9:2]] : 32'hBAD0_BAD0;
  end
  assign a_mem_rdata = pipe_a;

  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= init_word(i);
    end else if (b_mem_en && b_mem_we) begin
      for (int bi = 0; bi < 4; bi++)
        if (b_mem_be[bi]) mem_b[b_mem_addr[9:2]][8*bi +: 8] <= b_mem_wdata[8*bi +: 8];
    end
    pipe_b[0] <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr[9:2]] : 32'hBAD0_BAD0;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign b_mem_rdata = pipe_b[2];

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboards (sampled on falling edge) ----------------
  always @(negedge clk) begin
    if (!reset && (a_if_gnt || a_d_gnt)) chk("a_gnt_onehot", 128'(a_if_gnt && a_d_gnt), 128'd0);
    if (!reset && (a_if_rvalid || a_d_rvalid)) begin
      chk("a_rvalid_onehot", 128'(a_if_rvalid && a_d_rvalid), 128'd0);
      if (exp_qa.size() == 0) chk("a_unexpected_rvalid", 128'(exp_qa.size()), 128'd1);
      else begin
        ea = exp_qa.pop_front();
        chk("a_resp_port", 128'(a_d_rvalid), 128'(ea[32]));
        chk("a_resp_data", 128'(a_d_rvalid ? a_d_rdata : a_if_rdata), 128'(ea[31:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && (b_if_gnt || b_d_gnt)) chk("b_gnt_onehot", 128'(b_if_gnt && b_d_gnt), 128'd0);
    if (!reset && (b_if_rvalid || b_d_rvalid)) begin
      chk("b_rvalid_onehot", 128'(b_if_rvalid && b_d_rvalid), 128'd0);
      if (exp_qb.size() == 0) chk("b_unexpected_rvalid", 128'(exp_qb.size()), 128'd1);
      else begin
        eb = exp_qb.pop_front();
        chk("b_resp_port", 128'(b_d_rvalid), 128'(eb[32]));
        chk("b_resp_data", 128'(b_d_rvalid ? b_d_rdata : b_if_rdata), 128'(eb[31:0]));
      end
    end
  end

  // Both B ports request continuously for n grants; round-robin alternates I,D,...
  task automatic run_both_b(input int n);
    int grants = 0;
    int cyc = 0;
    int last_cyc = 0;
    b_if_req = 1'b1; b_if_addr = 32'h20;
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_be = 4'hF; b_d_addr = 32'h40;
    for (int k = 0; k < n; k++)
      exp_qb.push_back((k % 2 == 1) ? {1'b1, init_word(16)} : {1'b0, init_word(8)});
    while (grants < n && cyc < 40 * n) begin
      tick();
      cyc++;
      if (b_if_gnt || b_d_gnt) begin
        chk("b_rr_order", 128'(b_d_gnt), 128'(grants % 2));
        if (grants > 0) chk("b_grant_gap", 128'(cyc - last_cyc), 128'(B_LAT + 2));
        last_cyc = cyc;
        grants++;
      end
    end
    chk("b_grant_count", 128'(grants), 128'(n));
    b_if_req = 1'b0; b_d_req = 1'b0;
    repeat (B_LAT + 3) tick();
    chk("b_idle_after_burst", 128'(b_busy), 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [31:0] w;
  initial begin
    a_if_req = 0; a_if_addr = 0; a_d_req = 0; a_d_we = 0; a_d_be = 4'hF; a_d_addr = 0; a_d_wdata = 0;
    b_if_req = 0; b_if_addr = 0; b_d_req = 0; b_d_we = 0; b_d_be = 4'hF; b_d_addr = 0; b_d_wdata = 0;
    repeat (2) tick();
    mem_fill = 1'b0;

    // reset values
    chk("a_reset_ctl", {a_if_gnt, a_d_gnt, a_if_rvalid, a_d_rvalid, a_mem_en, a_mem_we,
                        a_mem_be, a_busy, a_dbg, a_cnt}, 128'd0);
    chk("a_reset_data", {a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata}, 128'd0);
    chk("b_reset_ctl", {b_if_gnt, b_d_gnt, b_if_rvalid, b_d_rvalid, b_mem_en, b_mem_we,
                        b_mem_be, b_busy, b_dbg, b_cnt}, 128'd0);
    reset = 1'b0;
    tick();

    // 1: single fetch, LAT=1
    a_if_req = 1'b1; a_if_addr = 32'h10;
    exp_qa.push_back({1'b0, 32'h0050_0093});
    tick();
    chk("t1_gnt", {a_if_gnt, a_d_gnt, a_mem_en, a_mem_we, a_mem_be, a_busy}, {4'b1010, 4'hF, 1'b1});
    chk("t1_mem_addr", a_mem_addr, 32'h10);
    a_if_req = 1'b0;
    tick();
    chk("t1_pulse_end", {a_if_gnt, a_mem_en}, 2'b00);
    tick();
    chk("t1_rvalid", a_if_rvalid, 1);
    tick();
    chk("t1_rvalid_end", a_if_rvalid, 0);
    chk("t1_rdata_hold", a_if_rdata, 32'h0050_0093);
    chk("t1_idle", {a_busy, a_dbg}, 3'd0);

    // 2: simultaneous requests, data port has priority
    a_if_req = 1'b1; a_if_addr = 32'h20;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_be = 4'hF; a_d_addr = 32'h100;
    exp_qa.push_back({1'b1, init_word(64)});
    exp_qa.push_back({1'b0, init_word(8)});
    tick();
    chk("t2_d_first", {a_d_gnt, a_if_gnt}, 2'b10);
    chk("t2_cnt", a_cnt, 1);
    chk("t2_addr", a_mem_addr, 32'h100);
    a_d_req = 1'b0;
    repeat (2) tick();
    chk("t2_d_resp", {a_d_rvalid, a_if_gnt}, 2'b10);
    tick();
    chk("t2_i_gnt", {a_if_gnt, a_d_rvalid}, 2'b10);
    chk("t2_i_addr", a_mem_addr, 32'h20);
    chk("t2_cnt_hold", a_cnt, 1);
    a_if_req = 1'b0;
    repeat (3) tick();
    chk("t2_idle", a_busy, 0);

    // 4: byte-enabled store, then read it back
    a_d_req = 1'b1; a_d_we = 1'b1; a_d_be = 4'b0011; a_d_addr = 32'h100; a_d_wdata = 32'hDEAD_BEEF;
    exp_qa.push_back({1'b1, init_word(64)});
    tick();
    chk("t4_strobe", {a_d_gnt, a_mem_en, a_mem_we, a_mem_be}, {3'b111, 4'b0011});
    chk("t4_wdata", a_mem_wdata, 32'hDEAD_BEEF);
    a_d_req = 1'b0; a_d_we = 1'b0;
    tick();
    chk("t4_strobe_end", {a_mem_en, a_mem_we}, 2'b00);
    chk("t4_wdata_hold", a_mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("t4_rvalid", a_d_rvalid, 1);
    tick();
    w = init_word(64);
    a_d_req = 1'b1; a_d_be = 4'hF; a_d_addr = 32'h100;
    exp_qa.push_back({1'b1, w[31:16], 16'hBEEF});
    tick();
    chk("t4_load_gnt", {a_d_gnt, a_mem_we}, 2'b10);
    a_d_req = 1'b0;
    repeat (3) tick();

    // 3: round-robin, both held for four transactions
    run_both_b(4);
    chk("t3_cnt", b_cnt, 4);

    // 5: LAT=3 load latency
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_be = 4'hF; b_d_addr = 32'h100;
    exp_qb.push_back({1'b1, init_word(64)});
    tick();
    chk("t5_gnt", b_d_gnt, 1);
    b_d_req = 1'b0;
    repeat (3) tick();
    chk("t5_no_rvalid_e4", b_d_rvalid, 0);
    tick();
    chk("t5_rvalid_e5", b_d_rvalid, 1);
    tick();
    chk("t5_rvalid_end", b_d_rvalid, 0);

    // 5b: reset while waiting on memory abandons the transaction
    b_d_req = 1'b1; b_d_addr = 32'h104;
    tick();
    chk("t5b_gnt", b_d_gnt, 1);
    b_d_req = 1'b0;
    repeat (2) tick();
    chk("t5b_in_wait", b_dbg, 2'd2);
    reset = 1'b1;
    #1;
    chk("t5b_reset_ctl", {b_if_gnt, b_d_gnt, b_if_rvalid, b_d_rvalid, b_mem_en, b_mem_we,
                          b_mem_be, b_busy, b_dbg, b_cnt}, 128'd0);
    chk("t5b_reset_data", {b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata}, 128'd0);
    tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("t5b_quiet", {b_d_rvalid, b_mem_en, b_busy}, 3'b000);
    b_d_req = 1'b1; b_d_addr = 32'h104;
    exp_qb.push_back({1'b1, init_word(65)});
    tick();
    chk("t5b_regnt", b_d_gnt, 1);
    b_d_req = 1'b0;
    repeat (4) tick();
    chk("t5b_rvalid", b_d_rvalid, 1);
    tick();

    // 6: counter saturation over 20 contended arbitrations
    chk("t6_cnt_start", b_cnt, 0);
    run_both_b(20);
    chk("t6_cnt_sat", b_cnt, 4'hF);

    repeat (2) tick();
    chk("qa_drained", 128'(exp_qa.size()), 128'd0);
    chk("qb_drained", 128'(exp_qb.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
